// File: rtl/sdram_port_arbiter.sv
// Two-client arbiter sharing one SDRAM controller port; one read burst or write in flight.
// Define SDRAM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default is fixed priority (client 0 wins).
module sdram_port_arbiter #(
    parameter int BURST_BEATS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        c0_req,
    input  logic        c0_rw,
    input  logic [31:0] c0_addr,
    input  logic [15:0] c0_wdata,
    input  logic        c1_req,
    input  logic        c1_rw,
    input  logic [31:0] c1_addr,
    input  logic [15:0] c1_wdata,
    output logic        c0_ack,
    output logic        c1_ack,
    output logic        c0_fill,
    output logic        c1_fill,
    output logic [15:0] rdata,
    output logic        sdram_req,
    output logic        sdram_rw,
    output logic [31:0] sdram_addr,
    output logic [15:0] sdram_wdata,
    input  logic        sdram_ack,
    input  logic        sdram_fill,
    input  logic [15:0] sdram_rdata,
    output logic        busy,
    output logic        protocol_err,
    output logic [1:0]  fsm_state
);

    localparam int CW = $clog2(BURST_BEATS);
    localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_BEATS - 1);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] RD_WAIT  = 2'd1;
    localparam logic [1:0] RD_BURST = 2'd2;
    localparam logic [1:0] WR_WAIT  = 2'd3;

    logic [1:0]    state;
    logic          grant;
    logic [CW-1:0] beat_cnt;
    logic          pick;
    logic          sel_rw;
    logic [31:0]   sel_addr;
    logic [15:0]   sel_wdata;
    logic          in_read;
    logic          stray;

    always_comb begin
        pick = 1'b0;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
        if (c0_req && c1_req) begin
            pick = ~grant;
        end else begin
            pick = !c0_req;
        end
`else
        pick = !c0_req;
`endif
    end

    assign sel_rw    = pick ? c1_rw    : c0_rw;
    assign sel_addr  = pick ? c1_addr  : c0_addr;
    assign sel_wdata = pick ? c1_wdata : c0_wdata;

    assign in_read   = (state == RD_WAIT) || (state == RD_BURST);
    assign busy      = (state != IDLE);
    assign fsm_state = state;
    assign rdata     = sdram_rdata;
    assign c0_fill   = sdram_fill && in_read && !grant;
    assign c1_fill   = sdram_fill && in_read &&  grant;

    // Any strobe the current state cannot legally receive; never forwarded.
    assign stray = ((state == IDLE) && (sdram_fill || sdram_ack)) ||
                   (in_read && sdram_ack) ||
                   ((state == WR_WAIT) && sdram_fill);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            grant        <= 1'b1;
            beat_cnt     <= '0;
            sdram_req    <= 1'b0;
            sdram_rw     <= 1'b1;
            sdram_addr   <= '0;
            sdram_wdata  <= '0;
            c0_ack       <= 1'b0;
            c1_ack       <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            c0_ack <= 1'b0;
            c1_ack <= 1'b0;
            if (stray) begin
                protocol_err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (c0_req || c1_req) begin
                        grant       <= pick;
                        sdram_req   <= 1'b1;
                        sdram_rw    <= sel_rw;
                        sdram_addr  <= sel_addr;
                        sdram_wdata <= sel_wdata;
                        state       <= sel_rw ? RD_WAIT : WR_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (sdram_fill) begin
                        sdram_req <= 1'b0;
                        beat_cnt  <= CW'(1);
                        state     <= RD_BURST;
                    end
                end
                RD_BURST: begin
                    // Exit on the last beat, so the counter never wraps.
                    if (sdram_fill) begin
                        if (beat_cnt == LAST_BEAT) begin
                            state <= IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + CW'(1);
                        end
                    end
                end
                WR_WAIT: begin
                    if (sdram_ack) begin
                        sdram_req <= 1'b0;
                        if (grant) begin
                            c1_ack <= 1'b1;
                        end else begin
                            c0_ack <= 1'b1;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed testbench for sdram_port_arbiter: vector table plus hand-written multi-cycle sequences.
// Inputs are driven and outputs sampled on the falling edge; the DUT acts on the rising edge.
module tb_sdram_port_arbiter;

    localparam int BEATS = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        c0_req, c0_rw, c1_req, c1_rw;
    logic [31:0] c0_addr, c1_addr;
    logic [15:0] c0_wdata, c1_wdata;
    logic        c0_ack, c1_ack, c0_fill, c1_fill;
    logic [15:0] rdata;
    logic        sdram_req, sdram_rw;
    logic [31:0] sdram_addr;
    logic [15:0] sdram_wdata;
    logic        sdram_ack, sdram_fill;
    logic [15:0] sdram_rdata;
    logic        busy, protocol_err;
    logic [1:0]  fsm_state;

    int checks   = 0;
    int failures = 0;

    // Scoreboard: each entry is {client, data} of a beat that must be forwarded.
    logic [16:0] exp_q[$];
    logic [16:0] exp_item;
    int          fill_cnt[2];

    sdram_port_arbiter #(.BURST_BEATS(BEATS)) dut (
        .clk(clk), .reset(reset),
        .c0_req(c0_req), .c0_rw(c0_rw), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
        .c1_req(c1_req), .c1_rw(c1_rw), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
        .c0_ack(c0_ack), .c1_ack(c1_ack), .c0_fill(c0_fill), .c1_fill(c1_fill),
        .rdata(rdata), .sdram_req(sdram_req), .sdram_rw(sdram_rw),
        .sdram_addr(sdram_addr), .sdram_wdata(sdram_wdata),
        .sdram_ack(sdram_ack), .sdram_fill(sdram_fill), .sdram_rdata(sdram_rdata),
        .busy(busy), .protocol_err(protocol_err), .fsm_state(fsm_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic clear_inputs();
        c0_req = 1'b0; c0_rw = 1'b0; c0_addr = '0; c0_wdata = '0;
        c1_req = 1'b0; c1_rw = 1'b0; c1_addr = '0; c1_wdata = '0;
        sdram_ack = 1'b0; sdram_fill = 1'b0; sdram_rdata = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // ---------------- checkers ----------------
    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (c0_fill || c1_fill) begin
            if (c0_fill) fill_cnt[0]++;
            if (c1_fill) fill_cnt[1]++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_fill actual=c0:%b c1:%b data=0x%0h required=no fill t=%0t",
                         c0_fill, c1_fill, rdata, $time);
            end else begin
                exp_item = exp_q.pop_front();
                check_val("fill_beat", 32'({c0_fill, c1_fill, rdata}),
                          32'({~exp_item[16], exp_item}));
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic drive_req(input int c, input logic rw, input logic [31:0] addr,
                             input logic [15:0] wd);
        if (c == 0) begin
            c0_req = 1'b1; c0_rw = rw; c0_addr = addr; c0_wdata = wd;
        end else begin
            c1_req = 1'b1; c1_rw = rw; c1_addr = addr; c1_wdata = wd;
        end
    endtask

    task automatic drop_req(input int c);
        if (c == 0) c0_req = 1'b0;
        else        c1_req = 1'b0;
    endtask

    task automatic grant_check(input logic rw, input logic [31:0] addr, input logic [15:0] wd);
        check_bit("grant_sdram_req", sdram_req, 1'b1);
        check_val("grant_sdram_addr", sdram_addr, addr);
        check_bit("grant_sdram_rw", sdram_rw, rw);
        check_val("grant_sdram_wdata", 32'(sdram_wdata), 32'(wd));
        check_bit("grant_busy", busy, 1'b1);
    endtask

    // Delivers a full burst for client c; starts and ends on a falling edge.
    task automatic run_burst(input int c, input logic [15:0] base, input bit gapped);
        int          before0 = fill_cnt[0];
        int          before1 = fill_cnt[1];
        logic [15:0] d;
        for (int i = 0; i < BEATS; i++) begin
            if (gapped && i > 0) repeat ((i % 3) + 1) @(negedge clk);
            check_bit("busy_in_burst", busy, 1'b1);
            d = base + 16'(i);
            exp_q.push_back({(c == 1), d});
            sdram_fill  = 1'b1;
            sdram_rdata = d;
            if (i == 0) drop_req(c);
            #1;
            check_val("rdata_passthru", 32'(rdata), 32'(d));
            @(negedge clk);
            sdram_fill = 1'b0;
            check_bit("sdram_req_low_after_beat", sdram_req, 1'b0);
        end
        check_bit("busy_after_burst", busy, 1'b0);
        check_val("c0_fill_count", 32'(fill_cnt[0] - before0), (c == 0) ? BEATS : 0);
        check_val("c1_fill_count", 32'(fill_cnt[1] - before1), (c == 1) ? BEATS : 0);
    endtask

    task automatic run_write(input int c);
        repeat (2) begin
            @(negedge clk);
            check_bit("wr_wait_req", sdram_req, 1'b1);
            check_bit("wr_wait_no_ack", c0_ack | c1_ack, 1'b0);
        end
        sdram_ack = 1'b1;
        #1;
        check_bit("ack_not_combinational", c0_ack | c1_ack, 1'b0);
        @(negedge clk);
        sdram_ack = 1'b0;
        drop_req(c);
        check_bit("c0_ack_pulse", c0_ack, (c == 0));
        check_bit("c1_ack_pulse", c1_ack, (c == 1));
        check_bit("busy_after_ack", busy, 1'b0);
        check_bit("sdram_req_after_ack", sdram_req, 1'b0);
        @(negedge clk);
        check_bit("ack_single_cycle", c0_ack | c1_ack, 1'b0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int          client;
        logic        rw;
        logic [31:0] addr;
        logic [15:0] wdata;
        logic [15:0] base;
        logic        exp_rw;
        logic [31:0] exp_addr;
        logic [15:0] exp_wdata;
    } vec_t;

    vec_t vecs[5];

    localparam logic [31:0] A0 = 32'h0000_0100;
    localparam logic [31:0] A1 = 32'h0000_0200;

    initial begin
        int exp_w;
        int pending;
        logic [15:0] d;

        vecs[0] = '{client: 0, rw: 1'b1, addr: 32'h0000_1230, wdata: 16'h0000, base: 16'hA000,
                    exp_rw: 1'b1, exp_addr: 32'h0000_1230, exp_wdata: 16'h0000};
        vecs[1] = '{client: 1, rw: 1'b0, addr: 32'h0000_0040, wdata: 16'hBEEF, base: 16'h0000,
                    exp_rw: 1'b0, exp_addr: 32'h0000_0040, exp_wdata: 16'hBEEF};
        vecs[2] = '{client: 1, rw: 1'b1, addr: 32'h8000_0000, wdata: 16'h1111, base: 16'h5A00,
                    exp_rw: 1'b1, exp_addr: 32'h8000_0000, exp_wdata: 16'h1111};
        vecs[3] = '{client: 0, rw: 1'b0, addr: 32'hFFFF_FFFC, wdata: 16'h0001, base: 16'h0000,
                    exp_rw: 1'b0, exp_addr: 32'hFFFF_FFFC, exp_wdata: 16'h0001};
        vecs[4] = '{client: 0, rw: 1'b1, addr: 32'h0000_0000, wdata: 16'hFFFF, base: 16'hFFFC,
                    exp_rw: 1'b1, exp_addr: 32'h0000_0000, exp_wdata: 16'hFFFF};

        fill_cnt[0] = 0;
        fill_cnt[1] = 0;
        do_reset();

        // Reset values
        check_bit("rst_sdram_req", sdram_req, 1'b0);
        check_bit("rst_sdram_rw", sdram_rw, 1'b1);
        check_val("rst_sdram_addr", sdram_addr, 32'h0);
        check_val("rst_sdram_wdata", 32'(sdram_wdata), 32'h0);
        check_bit("rst_acks", c0_ack | c1_ack, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_protocol_err", protocol_err, 1'b0);

        // Table-driven single transactions
        for (int i = 0; i < 5; i++) begin
            drive_req(vecs[i].client, vecs[i].rw, vecs[i].addr, vecs[i].wdata);
            @(negedge clk);
            grant_check(vecs[i].exp_rw, vecs[i].exp_addr, vecs[i].exp_wdata);
            if (vecs[i].rw) run_burst(vecs[i].client, vecs[i].base, 1'b0);
            else            run_write(vecs[i].client);
            @(negedge clk);
        end

        // Simultaneous reads, four rounds, both clients re-requesting immediately
        do_reset();
        for (int r = 0; r < 4; r++) begin
            drive_req(0, 1'b1, A0, 16'h0);
            drive_req(1, 1'b1, A1, 16'h0);
            @(negedge clk);
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
            exp_w = r % 2;
`else
            exp_w = 0;
`endif
            check_val("tie_grant_addr", sdram_addr, (exp_w == 1) ? A1 : A0);
            run_burst(exp_w, 16'h1000 * 16'(r + 1), 1'b0);
        end
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
        pending = 0;
`else
        pending = 1;
`endif
        @(negedge clk);
        check_val("sole_requester_addr", sdram_addr, (pending == 1) ? A1 : A0);
        run_burst(pending, 16'h7700, 1'b0);
        @(negedge clk);

        // Gapped burst
        drive_req(1, 1'b1, 32'h0000_3000, 16'h0);
        @(negedge clk);
        grant_check(1'b1, 32'h0000_3000, 16'h0);
        run_burst(1, 16'hC000, 1'b1);
        check_bit("err_clean_before_stray", protocol_err, 1'b0);

        // Stray ack in IDLE
        @(negedge clk);
        sdram_ack = 1'b1;
        @(negedge clk);
        sdram_ack = 1'b0;
        check_bit("stray_ack_sets_err", protocol_err, 1'b1);
        check_bit("stray_ack_no_client_ack", c0_ack | c1_ack, 1'b0);
        repeat (3) @(negedge clk);
        check_bit("stray_ack_err_sticky", protocol_err, 1'b1);
        check_bit("stray_ack_no_late_ack", c0_ack | c1_ack, 1'b0);

        // Reset after 3 of 8 beats
        do_reset();
        check_bit("rst2_protocol_err", protocol_err, 1'b0);
        drive_req(0, 1'b1, 32'h0000_1230, 16'h0);
        @(negedge clk);
        grant_check(1'b1, 32'h0000_1230, 16'h0);
        for (int i = 0; i < 3; i++) begin
            d = 16'hD000 + 16'(i);
            exp_q.push_back({1'b0, d});
            sdram_fill = 1'b1;
            sdram_rdata = d;
            if (i == 0) drop_req(0);
            @(negedge clk);
            sdram_fill = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_bit("midrst_sdram_req", sdram_req, 1'b0);
        check_bit("midrst_busy", busy, 1'b0);
        check_val("midrst_sdram_addr", sdram_addr, 32'h0);
        check_bit("midrst_sdram_rw", sdram_rw, 1'b1);
        check_bit("midrst_err", protocol_err, 1'b0);
        for (int i = 3; i < BEATS; i++) begin
            sdram_fill = 1'b1;
            sdram_rdata = 16'hD000 + 16'(i);
            #1;
            check_bit("midrst_no_fill", c0_fill | c1_fill, 1'b0);
            @(negedge clk);
            sdram_fill = 1'b0;
        end
        check_bit("midrst_late_fill_err", protocol_err, 1'b1);
        drive_req(1, 1'b0, 32'h0000_0044, 16'h1234);
        @(negedge clk);
        grant_check(1'b0, 32'h0000_0044, 16'h1234);
        run_write(1);
        check_bit("err_sticky_after_write", protocol_err, 1'b1);

        // Stray fill during a write
        do_reset();
        drive_req(0, 1'b0, 32'h0000_0080, 16'h5555);
        @(negedge clk);
        grant_check(1'b0, 32'h0000_0080, 16'h5555);
        sdram_fill = 1'b1;
        sdram_rdata = 16'h9999;
        #1;
        check_bit("wr_stray_fill_not_fwd", c0_fill | c1_fill, 1'b0);
        @(negedge clk);
        sdram_fill = 1'b0;
        check_bit("wr_stray_fill_err", protocol_err, 1'b1);
        run_write(0);

        check_val("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Two-client arbiter sharing one SDRAM controller port between cache-side requesters, e.g. instruction cache and data cache/write path. Each client sees the same level-request, fill-strobe protocol the caches already use toward SDRAM. One transaction is in flight at a time: a read burst or a single-word write. The block sits between the caches and the SDRAM controller.

## Interface
- BURST_BEATS, 8: fill beats per read burst; power of two, 2–16.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- c0_req / c1_req  in  1  client request; level; held until served.
- c0_rw / c1_rw  in  1  1 = read burst, 0 = write.
- c0_addr / c1_addr  in  32  client address.
- c0_wdata / c1_wdata  in  16  client write data.
- c0_ack / c1_ack  out  1  one-cycle pulse when the client's write completes.
- c0_fill / c1_fill  out  1  read beat valid for this client.
- rdata  out  16  read data to both clients; equals sdram_rdata.
- sdram_req  out  1  request to controller.
- sdram_rw  out  1  registered copy of the granted rw.
- sdram_addr  out  32  registered copy of the granted address.
- sdram_wdata  out  16  registered copy of the granted wdata.
- sdram_ack  in  1  controller write-complete strobe.
- sdram_fill  in  1  controller read-beat strobe.
- sdram_rdata  in  16  controller read data.
- busy  out  1  high in any state other than IDLE.
- protocol_err  out  1  sticky; cleared only by reset.

## Operation
- States:
  - IDLE: sdram_req=0.
    - If a request is pending, pick a winner and latch its addr/rw/wdata into sdram_*.
    - Go to RD_WAIT if rw=1, otherwise WR_WAIT.
  - RD_WAIT: sdram_req=1.
    - On sdram_fill: sdram_req←0, beat counter←1, go to RD_BURST.
    - The first beat is forwarded.
  - RD_BURST: every sdram_fill is forwarded and increments the counter.
    - On the beat where counter==BURST_BEATS-1, go to IDLE.
    - Cycles without sdram_fill are legal gaps.
  - WR_WAIT: sdram_req=1.
    - On sdram_ack: sdram_req←0, pulse cN_ack for the granted client, go to IDLE.
- Forwarding is combinational:
  - cN_fill = sdram_fill & (state∈{RD_WAIT,RD_BURST}) & (grant==N).
  - rdata = sdram_rdata at all times.
- Clients:
  - A read client may drop req on or after its first fill.
  - A write client holds req until its ack.
  - A client dropping req before being served is ignored. The transaction still completes and its beats/ack are still delivered.
- Grant is held for the whole transaction. Requests arriving meanwhile wait.
- protocol_err is set when sdram_fill or sdram_ack is seen in IDLE, or when sdram_ack is seen in RD_*, or when sdram_fill is seen in WR_WAIT. Stray strobes are never forwarded.
- Counter width is $clog2(BURST_BEATS). Wrap-around is impossible because the exit happens on the last beat.

## Timing
- Reset values: state IDLE, sdram_req=0, sdram_rw=1, sdram_addr=0, sdram_wdata=0, c0_ack=c1_ack=0, busy=0, protocol_err=0, grant=1 (last-granted=client 1).
- Request latency: a req sampled high in IDLE at edge t gives sdram_req=1 and valid sdram_addr after t.
- Back-to-back: after the last beat or ack, IDLE occupies one cycle. A next grant's sdram_req rises two cycles after that final strobe.
- Fill has zero latency to the client. Write ack reaches the client one cycle after sdram_ack.
- Reset mid-transaction:
  - Everything returns to reset values next edge.
  - Later fill beats are not forwarded and do set protocol_err, since state is IDLE.
  - The SDRAM controller is expected to be reset by the same signal.

## Configuration
- SDRAM_ARB_ROUND_ROBIN_EN defined:
  - On simultaneous requests, the client not granted last wins.
  - After reset, client 0 wins the first tie.
  - A sole requester always wins.
- Undefined: fixed priority; client 0 always beats client 1. Client 1 can starve under continuous client 0 traffic.

## Test plan
- Single read: c0 read addr 0x0000_1230. Expect:
  - sdram_req high next cycle, sdram_addr=0x0000_1230, sdram_rw=1.
  - 8 fills of data 0xA000..0xA007 produce exactly 8 c0_fill with matching rdata and 0 c1_fill.
  - busy drops after beat 8.
- Write: c1 write addr 0x40, data 0xBEEF. Expect:
  - sdram_wdata=0xBEEF, sdram_rw=0.
  - sdram_ack gives one c1_ack pulse on the next cycle and no c0_ack.
- Simultaneous reads from c0 and c1, repeated 4 times:
  - With round-robin: grant order 0,1,0,1.
  - Without: c0 served first every time c0 re-requests immediately.
- Gapped burst: 8 fills with 1–3 idle cycles between beats. Expect all 8 forwarded, then IDLE; sdram_req low from the first beat on.
- Reset after 3 of 8 beats: remaining 5 fills produce no cN_fill, protocol_err=1, and the next request is served normally.
- Stray sdram_ack in IDLE: protocol_err goes to 1 and stays there; no cN_ack.
